stream_restore: RTL and testbench

Receive-side counterpart of the delayed-subtract stream stage. Accepts the valid-qualified, subtracted 32-bit stream and adds the subtrahend back to recover the original sample. Buffers results in a small FIFO so a downstream consumer can apply ready/valid backpressure that the upstream stage cannot honour. Sits directly after the delay/subtract pipeline at the consumer end of the datapath.

---
 rtl/stream_restore.sv | 131 +++++++++++++
 tb/tb_stream_restore.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stream_restore.sv
// stream_restore: receive-side restore stage for the delayed-subtract stream.
// Re-adds the subtrahend to each valid sample and buffers the restored value
// in a G_DEPTH-entry FIFO so the consumer can apply ready/valid backpressure
// that the upstream stage cannot honour.
// Optional feature: define STREAM_RESTORE_STATS_EN to compile the accept/drop
// counters; otherwise accept_count and drop_count are tied to zero.
module stream_restore #(
  parameter int G_WIDTH = 32,
  parameter int G_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [G_WIDTH-1:0]         data_in,
  input  logic [G_WIDTH-1:0]         add_back,
  input  logic                       data_in_valid,
  output logic [G_WIDTH-1:0]         data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [$clog2(G_DEPTH):0]   level,
  output logic                       overflow,
  output logic [31:0]                accept_count,
  output logic [31:0]                drop_count
);

  localparam int PW = $clog2(G_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(G_DEPTH);

  // Modular restore: the carry out of the top bit is intentionally discarded.
  function automatic logic [G_WIDTH-1:0] restore_sample(
    input logic [G_WIDTH-1:0] sub_val,
    input logic [G_WIDTH-1:0] add_val
  );
    return sub_val + add_val;
  endfunction

  logic [G_WIDTH-1:0] mem_r [G_DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [LW-1:0]      level_r;
  logic               overflow_r;

  logic               full_s;
  logic               empty_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic               drop_s;
  logic [LW-1:0]      level_nxt_s;
  logic [G_WIDTH-1:0] restored_s;

  // Write/read/drop qualification; fullness is judged on pre-edge occupancy,
  // so a same-cycle read never makes room for a write into a full FIFO.
  always_comb begin
    full_s     = (level_r == FULL_LEVEL);
    empty_s    = (level_r == {LW{1'b0}});
    wr_en_s    = data_in_valid & ~full_s;
    drop_s     = data_in_valid & full_s;
    rd_en_s    = data_out_ready & ~empty_s;
    restored_s = restore_sample(data_in, add_back);
  end

  // Next occupancy from the write/read pair; simultaneous write and read cancel.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Sample storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[wr_ptr_r] <= restored_s;
    end
  end

  // Pointers, occupancy and sticky overflow; reset beats any same-cycle access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef STREAM_RESTORE_STATS_EN
  logic [31:0] accept_cnt_r;
  logic [31:0] drop_cnt_r;

  // Free-running statistics counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_r <= 32'd0;
      drop_cnt_r   <= 32'd0;
    end else begin
      if (wr_en_s) begin
        accept_cnt_r <= accept_cnt_r + 32'd1;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end

  assign accept_count = accept_cnt_r;
  assign drop_count   = drop_cnt_r;
`else
  assign accept_count = 32'd0;
  assign drop_count   = 32'd0;
`endif

  assign data_out       = mem_r[rd_ptr_r];
  assign data_out_valid = ~empty_s;
  assign level          = level_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_stream_restore.sv
// Self-checking bench for stream_restore: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_stream_restore;

  localparam int DEPTH = 8;
`ifdef STREAM_RESTORE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] add_back;
  logic        data_in_valid;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic [31:0] accept_count;
  logic [31:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_ovf;
  logic [31:0] m_acc;
  logic [31:0] m_drop;

  stream_restore #(.G_WIDTH(32), .G_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .add_back(add_back),
    .data_in_valid(data_in_valid), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .level(level), .overflow(overflow), .accept_count(accept_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(m_q.size()));
    chk("valid", 32'(data_out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("data", data_out, m_q[0]);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("accept", accept_count, STATS ? m_acc : 32'd0);
    chk("drop", drop_count, STATS ? m_drop : 32'd0);
  endtask

  // One clock: apply inputs, let the edge happen, step the model, check.
  task automatic cyc(input bit r, input bit v, input logic [31:0] d,
                     input logic [31:0] a, input bit rdy);
    bit full;
    bit rd;
    rst = r; data_in_valid = v; data_in = d; add_back = a; data_out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_ovf = 1'b0; m_acc = 32'd0; m_drop = 32'd0;
    end else begin
      full = (m_q.size() == DEPTH);
      rd   = rdy && (m_q.size() != 0);
      if (rd) void'(m_q.pop_front());
      if (v && !full) begin
        m_q.push_back(d + a);
        m_acc = m_acc + 32'd1;
      end
      if (v && full) begin
        m_ovf = 1'b1;
        m_drop = m_drop + 32'd1;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    m_ovf = 1'b0; m_acc = 32'd0; m_drop = 32'd0;
    rst = 1'b1; data_in = 32'd0; add_back = 32'd0;
    data_in_valid = 1'b0; data_out_ready = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);

    // Basic restore, one-cycle latency, then empty
    cyc(1'b0, 1'b1, 32'h0000000A, 32'h00000005, 1'b1);
    chk("restore_data", data_out, 32'h0000000F);
    chk("restore_valid", 32'(data_out_valid), 32'd1);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("restore_empty", 32'(data_out_valid), 32'd0);

    // Modular wrap
    cyc(1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b1);
    chk("wrap_data", data_out, 32'h00000001);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    // Fill and overflow
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, 32'(i), 32'd0, 1'b0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_drop", drop_count, STATS ? 32'd1 : 32'd0);
    chk("fill_head", data_out, 32'd1);

    // Full with simultaneous read: read happens, write dropped
    cyc(1'b0, 1'b1, 32'd99, 32'd0, 1'b1);
    chk("fullrd_level", 32'(level), 32'd7);
    chk("fullrd_head", data_out, 32'd2);
    chk("fullrd_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("drain_empty", 32'(data_out_valid), 32'd0);

    // Pointer wrap at full throughput
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 32'(100 + i), 32'd0, 1'b1);
      chk("stream_data", data_out, 32'(100 + i));
      chk("stream_le1", 32'(level <= 4'd1), 32'd1);
    end
    chk("stream_acc", accept_count, STATS ? 32'd20 : 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    // Reset mid-operation with a valid input in the reset cycle
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 32'(50 + i), 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("mid_level", 32'(level), 32'd5);
    chk("mid_ovf", 32'(overflow), 32'd1);
    cyc(1'b1, 1'b1, 32'h12345678, 32'd1, 1'b1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(data_out_valid), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_acc", accept_count, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("midrst_nostore", 32'(data_out_valid), 32'd0);

    // Randomized traffic with bursty backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      bit r_b;
      bit v_b;
      bit rdy_b;
      r_b   = ($urandom_range(0, 199) == 0);
      v_b   = ($urandom_range(0, 99) < 70);
      rdy_b = ((i / 64) % 2 == 0) ? ($urandom_range(0, 99) < 80)
                                  : ($urandom_range(0, 99) < 30);
      cyc(r_b, v_b, $urandom, $urandom, rdy_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
